note_scroller: RTL

NOTE_SCROLLER -- requirements
Module: note_scroller

---
 rtl/note_pkg.sv | 24 ++
 rtl/note_lane.sv | 32 +++
 rtl/note_scroller.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/note_pkg.sv
// Shared types and constants for the note scroller.
// Holds the FSM state encoding and the saturating score adder.
package note_pkg;

    localparam int SCORE_W     = 8;
    localparam int SONG_ADDR_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_FLUSH,
        ST_DONE
    } state_t;

    function automatic logic [SCORE_W-1:0] sat_add(
        input logic [SCORE_W-1:0] a,
        input logic [SCORE_W-1:0] b
    );
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/note_lane.sv
// One lane of falling notes: row 0 enters at the top,
// row DEPTH-1 is the hit row.
module note_lane #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_load,
    input  logic             i_clr_hit,
    output logic [DEPTH-1:0] o_rows,
    output logic             o_hit
);

    logic [DEPTH-1:0] r_rows;

    // A shift already drops the hit row, so clearing only matters without one
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_rows <= '0;
        end else if (i_shift) begin
            r_rows <= {r_rows[DEPTH-2:0], i_load};
        end else if (i_clr_hit) begin
            r_rows[DEPTH-1] <= 1'b0;
        end
    end

    assign o_rows = r_rows;
    assign o_hit  = r_rows[DEPTH-1];

endmodule

// File: rtl/note_scroller.sv
// Rhythm-game note scroller: lanes scroll on tick, buttons score hits/misses.
// Optional streak output enabled by NOTE_SCROLLER_STREAK_EN.
module note_scroller
    import note_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int DEPTH    = 8,
    parameter int SONG_LEN = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   start,
    input  logic [LANES-1:0]       btn,
    output logic [SONG_ADDR_W-1:0] song_addr,
    input  logic [LANES-1:0]       song_row,
    output logic [LANES*DEPTH-1:0] lanes,
    output logic [SCORE_W-1:0]     hits,
    output logic [SCORE_W-1:0]     misses,
`ifdef NOTE_SCROLLER_STREAK_EN
    output logic [SCORE_W-1:0]     streak,
`endif
    output logic                   playing,
    output logic                   song_done
);

    localparam int FW = $clog2(DEPTH + 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [SONG_ADDR_W-1:0] r_addr;
    logic [FW-1:0]          r_flush;
    logic [LANES-1:0]       r_btn;
    logic [SCORE_W-1:0]     r_hits;
    logic [SCORE_W-1:0]     r_misses;

    logic             w_active;
    logic             w_begin;
    logic             w_shift;
    logic             w_last_row;
    logic             w_flush_end;
    logic [LANES-1:0] w_edge;
    logic [LANES-1:0] w_hitrow;
    logic [LANES-1:0] w_hit_lanes;
    logic [LANES-1:0] w_wrong;
    logic [LANES-1:0] w_lost;
    logic [LANES-1:0] w_load;
    logic [SCORE_W-1:0] w_n_hit;
    logic [SCORE_W-1:0] w_n_miss;

    assign w_active    = (r_state == ST_PLAY) || (r_state == ST_FLUSH);
    assign w_begin     = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_shift     = tick && w_active;
    assign w_last_row  = r_addr == SONG_ADDR_W'(SONG_LEN - 1);
    assign w_flush_end = r_flush == FW'(DEPTH - 1);

    // Edges judged on the pre-shift hit row; a hit bit never also counts as lost
    assign w_edge      = w_active ? (btn & ~r_btn) : '0;
    assign w_hit_lanes = w_edge & w_hitrow;
    assign w_wrong     = w_edge & ~w_hitrow;
    assign w_lost      = w_shift ? (w_hitrow & ~w_hit_lanes) : '0;
    assign w_load      = (r_state == ST_PLAY) ? song_row : '0;

    always_comb begin
        w_n_hit  = '0;
        w_n_miss = '0;
        for (int l = 0; l < LANES; l++) begin
            w_n_hit  = w_n_hit + SCORE_W'(w_hit_lanes[l]);
            w_n_miss = w_n_miss + SCORE_W'(w_wrong[l]) + SCORE_W'(w_lost[l]);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: if (start) w_next = ST_PLAY;
            ST_PLAY:  if (tick && w_last_row) w_next = ST_FLUSH;
            ST_FLUSH: if (tick && w_flush_end) w_next = ST_DONE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn    <= '0;
            r_addr   <= '0;
            r_flush  <= '0;
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            r_btn <= btn;
            if (w_begin) begin
                r_addr   <= '0;
                r_flush  <= '0;
                r_hits   <= '0;
                r_misses <= '0;
            end else begin
                r_hits   <= sat_add(r_hits, w_n_hit);
                r_misses <= sat_add(r_misses, w_n_miss);
                if (w_shift && r_state == ST_PLAY) begin
                    r_addr <= r_addr + 1'b1;
                    if (w_last_row) r_flush <= '0;
                end else if (w_shift) begin
                    r_flush <= r_flush + 1'b1;
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        note_lane #(.DEPTH(DEPTH)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_clear  (w_begin),
            .i_shift  (w_shift),
            .i_load   (w_load[l]),
            .i_clr_hit(w_hit_lanes[l]),
            .o_rows   (lanes[l*DEPTH +: DEPTH]),
            .o_hit    (w_hitrow[l])
        );
    end

`ifdef NOTE_SCROLLER_STREAK_EN
    logic [SCORE_W-1:0] r_streak;

    always_ff @(posedge clk) begin
        if (rst || w_begin)      r_streak <= '0;
        else if (w_n_miss != '0) r_streak <= w_n_hit;
        else                     r_streak <= sat_add(r_streak, w_n_hit);
    end

    assign streak = r_streak;
`endif

    assign song_addr = r_addr;
    assign hits      = r_hits;
    assign misses    = r_misses;
    assign playing   = r_state == ST_PLAY;
    assign song_done = r_state == ST_DONE;

endmodule
